uart_tx_serializer: RTL and testbench

//  UART transmit stage that sits directly downstream of the 8-deep byte FIFO.

---
 rtl/uart_tx_serializer.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter popping bytes from an upstream FIFO; parity stage enabled by UART_TX_PARITY_EN.
// Latency: tx falls 3 clk edges after fifo_empty low is seen in IDLE; 3 tx-high gap cycles between frames.
// Backpressure: pops only from IDLE; a byte whose data_valid misses the WAIT cycle is dropped.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fifo_empty,
    output logic       read_en,
    input  logic       data_valid,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_end;

`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign bit_end = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = FETCH;
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (data_valid) begin
                    shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^fifo_data) ^ 1'(PARITY_ODD);
`endif
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx is decoded from state so reset drives the line high without waiting for a clock.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = par_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign read_en = (state_q == FETCH);
    assign tx_busy = (state_q != IDLE);
    assign tx_done = (state_q == STOP) && bit_end && (idx_q == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (1 stop/even, 2 stop/odd) fed by FIFO models;
// expected frames are queued at enqueue time and checked by per-instance line monitors.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    typedef struct {
        logic [7:0] b;
        bit         drop;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] fifo_empty, read_en, data_valid, tx, tx_busy, tx_done;
    logic [7:0] fifo_data [2];

    ent_t       fq     [2][$];
    logic [7:0] exp_q  [2][$];
    int         starts [2][$];
    bit         in_frame [2];
    int         rd_cnt [2];
    int         done_cnt [2];
    int         exp_rd [2];
    int         exp_done [2];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty[0]), .read_en(read_en[0]),
        .data_valid(data_valid[0]), .fifo_data(fifo_data[0]), .tx(tx[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty[1]), .read_en(read_en[1]),
        .data_valid(data_valid[1]), .fifo_data(fifo_data[1]), .tx(tx[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

    function automatic int stops(input int id);
        return id + 1;
    endfunction

    function automatic int odd(input int id);
        return id;
    endfunction

    function automatic int frame_len(input int id);
        return (1 + 8 + PBITS + stops(id)) * CPB;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input int id, input logic [7:0] b, input bit drop);
        ent_t e;
        e.b    = b;
        e.drop = drop;
        fq[id].push_back(e);
        exp_rd[id]++;
        if (!drop) begin
            exp_q[id].push_back(b);
            exp_done[id]++;
        end
    endtask

    // FIFO model: data_valid appears in the cycle after the read_en cycle, unless the entry is a drop.
    task automatic fifo_drv(input int id);
        bit         pend = 1'b0;
        logic [7:0] pb   = 8'h00;
        forever begin
            @(negedge clk);
            data_valid[id] = 1'b0;
            fifo_data[id]  = 8'($urandom);
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    data_valid[id] = 1'b1;
                    fifo_data[id]  = pb;
                    pend           = 1'b0;
                end
                if (read_en[id]) begin
                    check($sformatf("rd_nonempty%0d", id), fq[id].size() > 0, 1);
                    if (fq[id].size() > 0) begin
                        ent_t e;
                        e = fq[id].pop_front();
                        if (!e.drop) begin
                            pend = 1'b1;
                            pb   = e.b;
                        end
                    end
                end
            end
            fifo_empty[id] = (fq[id].size() == 0);
        end
    endtask

    task automatic monitor(input int id);
        int         cyc     = 0;
        int         pos     = 0;
        int         last_rd = -100;
        logic       prev_tx = 1'b1;
        logic       prev_busy = 1'b0;
        logic       lv[$];
        logic [7:0] b;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                in_frame[id] = 1'b0;
                prev_tx      = 1'b1;
                prev_busy    = 1'b0;
            end else begin
                if (read_en[id]) begin
                    check($sformatf("rd_from_idle%0d", id), prev_busy, 0);
                    rd_cnt[id]++;
                    last_rd = cyc;
                end
                if (!in_frame[id] && prev_tx && !tx[id]) begin
                    check($sformatf("start_latency%0d", id), cyc - last_rd, 2);
                    check($sformatf("frame_expected%0d", id), exp_q[id].size() > 0, 1);
                    b = 8'h00;
                    if (exp_q[id].size() > 0) b = exp_q[id].pop_front();
                    lv.delete();
                    lv.push_back(1'b0);
                    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
                    if (PBITS == 1) lv.push_back(1'(($countones(b) + odd(id)) % 2));
                    for (int s = 0; s < stops(id); s++) lv.push_back(1'b1);
                    starts[id].push_back(cyc);
                    in_frame[id] = 1'b1;
                    pos          = 0;
                end
                if (in_frame[id]) begin
                    check($sformatf("tx%0d_bit%0d", id, pos / CPB), tx[id], lv[pos / CPB]);
                    check($sformatf("tx_done%0d_pos%0d", id, pos), tx_done[id], pos == frame_len(id) - 1);
                    check($sformatf("tx_busy%0d", id), tx_busy[id], 1);
                    pos++;
                    if (pos == frame_len(id)) begin
                        in_frame[id] = 1'b0;
                        done_cnt[id]++;
                    end
                end else begin
                    check($sformatf("tx_done_idle%0d", id), tx_done[id], 0);
                end
            end
            prev_tx   = tx[id];
            prev_busy = tx_busy[id];
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        repeat (3) @(negedge clk);
        while (!(fq[0].size() == 0 && fq[1].size() == 0 && exp_q[0].size() == 0 &&
                 exp_q[1].size() == 0 && tx_busy == 2'b00 && !in_frame[0] && !in_frame[1] &&
                 data_valid == 2'b00) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, n < 3000, 1);
        repeat (2) @(negedge clk);
        for (int id = 0; id < 2; id++) begin
            check($sformatf("%s_frames%0d", name, id), done_cnt[id], exp_done[id]);
            check($sformatf("%s_reads%0d", name, id), rd_cnt[id], exp_rd[id]);
        end
    endtask

    initial begin
        int n;
        int w;
        reset_n       = 1'b0;
        fifo_empty    = 2'b11;
        data_valid    = 2'b00;
        fifo_data[0]  = 8'h00;
        fifo_data[1]  = 8'h00;
        for (int id = 0; id < 2; id++) begin
            in_frame[id] = 1'b0;
            rd_cnt[id] = 0;  done_cnt[id] = 0;
            exp_rd[id] = 0;  exp_done[id] = 0;
        end
        fork
            fifo_drv(0);
            fifo_drv(1);
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(negedge clk);
        for (int id = 0; id < 2; id++) begin
            check($sformatf("reset_tx%0d", id), tx[id], 1);
            check($sformatf("reset_busy%0d", id), tx_busy[id], 0);
            check($sformatf("reset_rd%0d", id), read_en[id], 0);
            check($sformatf("reset_done%0d", id), tx_done[id], 0);
        end
        reset_n = 1'b1;

        // single byte on the 1-stop instance, 0x55 on the 2-stop instance
        push_byte(0, 8'hA5, 1'b0);
        push_byte(1, 8'h55, 1'b0);
        wait_idle("single");

        // parity values (even on instance 0, odd on instance 1)
        push_byte(0, 8'hA5, 1'b0);
        push_byte(1, 8'h01, 1'b0);
        wait_idle("parity");

        // back-to-back frames and the 3-cycle inter-frame gap
        push_byte(0, 8'h00, 1'b0);
        push_byte(0, 8'hFF, 1'b0);
        wait_idle("b2b");
        n = starts[0].size();
        check("b2b_gap", starts[0][n-1] - starts[0][n-2], frame_len(0) + 3);

        // data_valid missing in WAIT: the pop happens but no frame follows
        n = starts[0].size();
        push_byte(0, 8'h99, 1'b1);
        wait_idle("drop");
        check("drop_no_frame", starts[0].size(), n);

        // randomized traffic with occasional drops
        for (int k = 0; k < 24; k++) begin
            push_byte(int'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_idle("random");

        // reset during data bit 3, then a clean 0x3C frame
        n = starts[0].size();
        push_byte(0, 8'($urandom), 1'b0);
        w = 0;
        while (starts[0].size() == n && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("reset_frame_start", w < 200, 1);
        repeat (CPB * 4 + 1) @(negedge clk);
        #2;
        reset_n = 1'b0;
        exp_done[0]--;
        #1;
        check("midreset_tx", tx[0], 1);
        check("midreset_busy", tx_busy[0], 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        push_byte(0, 8'h3C, 1'b0);
        wait_idle("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
